wf_switch_allocator: RTL and testbench
======================================

Name: wf_switch_allocator

Overview:
- Output-port allocator for one mesh router; sits directly downstream of the per-input West-First routing logic.
- Takes each input port's one-hot output request (0 Right, 1 Left, 2 Up, 3 Down, 4 Eject) plus flit valid/tail flags.
- Arbitrates each output port round-robin and holds the winning input (wormhole lock) until its tail flit has passed.
- Drives input grants and crossbar select per output.

Parameters:
- NP, 5, number of router ports (inputs = outputs = NP; port index = direction code).
- PW, 3, port index width; PW = ceil(log2(NP)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NP  input i presents a flit this cycle.
- in_req  input  NP*NP  in_req[NP*i+d]=1: input i requests output d (routing logic vector of input i).
- in_tail  input  NP  flit at input i is a packet's last flit.
- out_ready  input  NP  output d can accept a flit this cycle (downstream credit available).
- in_grant  output  NP  flit at input i transfers this cycle; upstream pops it.
- out_valid  output  NP  output d carries a flit this cycle.
- out_sel  output  NP*PW  out_sel[PW*d +: PW] = input index switched to output d.
- out_tail  output  NP  flit on output d is a tail.

Behaviour:
- Reset: all outputs IDLE, owner=0, rr_ptr=0. in_grant, out_valid, out_sel, out_tail are 0 while reset is high, independent of inputs.
- Outputs are combinational from current state and inputs; zero-latency grant. State registers update on the clock edge after a transfer.
- Request qualification: input i targets output d only if in_valid[i]=1 and d is the lowest set bit of in_req[NP*i +: NP]. Multi-hot: lower bits win, higher bits are ignored. All-zero: no request.
- Upstream holds the request constant for a whole packet. The allocator does not check this.
- Per-output FSM, IDLE state:
  - Candidates are the qualified inputs targeting d.
  - Winner is the first candidate at or after rr_ptr, cyclic over 0..NP-1.
  - If candidates exist and out_ready[d]=1: in_grant[winner]=1, out_valid[d]=1, out_sel=winner, out_tail[d]=in_tail[winner].
  - Next cycle rr_ptr = (winner+1) mod NP.
  - Next state is LOCKED with owner=winner, unless in_tail[winner]=1 (single-flit packet), in which case it stays IDLE.
  - If out_ready[d]=0: no grant, no pointer or state change.
- Per-output FSM, LOCKED state:
  - Only the owner is served; other requests for d are ignored, with no grant and no pointer change.
  - Transfer when in_valid[owner] & out_ready[d] & owner qualifies for d. This drives in_grant[owner]=1, out_valid[d]=1, out_sel=owner, out_tail[d]=in_tail[owner].
  - Tail transferred: go to IDLE. Otherwise stay LOCKED; stalls (valid or ready low) hold state.
- No transfer on output d: out_sel[d] = owner when LOCKED, 0 when IDLE.
- An input targets at most one output, so at most one in_grant bit per input is possible.
- Eject (d=4) uses the same rules; out_ready[4] reflects local sink readiness.
- Reset mid-packet: all locks clear immediately. The upstream partial packet is not recovered; system reset covers it.
- rr_ptr wrap: pointer NP-1 advances to 0. Pointer values >= NP cannot occur.

Decomposition:
- noc_pkg holds:
  - direction constants DIR_RIGHT=0, DIR_LEFT=1, DIR_UP=2, DIR_DOWN=3, DIR_EJECT=4;
  - NP and PW defaults;
  - the per-output state encoding (IDLE=0, LOCKED=1).
- Sub-module rr_arbiter (NP-wide: request vector + pointer -> one-hot grant + encoded index), instantiated once per output.
- Lock FSM, owner and rr_ptr registers live in wf_switch_allocator.

Test Plan:
- Reset: hold reset high with all in_valid=1 and all in_req set -> all in_grant, out_valid, out_sel, out_tail read 0. Release reset; first single-flit request 0->Right with ready=1 -> grant in cycle 1.
- Contention: inputs 1, 2, 3 each request output 0 with single-flit packets, ready=1 every cycle -> grants go to input 1, then 2, then 3, then 1, one per cycle; rr_ptr wraps 4->0 when input 4 is added.
- Wormhole lock: input 2 sends a 4-flit packet to output 3 while input 0 also requests output 3 -> out_sel[3]=2 for all 4 flits. Input 0 is granted the cycle after the tail; no interleaving.
- Backpressure: output 1 locked to input 4, out_ready[1]=0 for 3 cycles mid-packet -> no grant and state held; resumes from the same flit when ready returns; in_valid gaps behave the same.
- Parallel outputs: inputs 0->Eject, 1->Up, 3->Left in the same cycle with all ready -> three grants and three out_valid in the same cycle, with the correct out_sel for each.
- Reset mid-packet: assert reset on the 2nd flit of a 3-flit packet -> locks clear at once. After release, a different input wins that output immediately; multi-hot in_req=5'b01100 routes to Up (bit 2).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and types for the mesh router switch allocator.
//   - Direction codes double as router port indices.
//   - NP/PW defaults for a 5-port mesh router.
//   - Per-output lock state encoding.
package noc_pkg;

    localparam int unsigned DIR_RIGHT = 0;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_UP    = 2;
    localparam int unsigned DIR_DOWN  = 3;
    localparam int unsigned DIR_EJECT = 4;

    localparam int unsigned NP_DEF = 5;
    localparam int unsigned PW_DEF = 3;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over NP requesters.
//   req_i : request vector
//   ptr_i : highest-priority index (searched first, then cyclically upward)
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : encoded index of the granted requester (0 when none)
//   any_o : at least one request present
module rr_arbiter #(
    parameter int unsigned NP = 5,
    parameter int unsigned PW = 3
) (
    input  logic [NP-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NP-1:0] gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    // One extra bit so ptr + k cannot overflow before the modulo fold.
    logic [PW:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            cand = {1'b0, ptr_i} + (PW+1)'(k);
            if (cand >= (PW+1)'(NP)) begin
                cand = cand - (PW+1)'(NP);
            end
            if (!any_o && req_i[cand[PW-1:0]]) begin
                any_o                 = 1'b1;
                gnt_o[cand[PW-1:0]]   = 1'b1;
                idx_o                 = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/wf_switch_allocator.sv
// Output-port allocator for one West-First mesh router.
// Each output arbitrates round-robin among inputs whose routing vector targets it,
// then holds the winner (wormhole lock) until its tail flit has transferred.
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : input i presents a flit
//   in_req     : per-input one-hot output request, in_req[NP*i+d]
//   in_tail    : flit at input i is a tail
//   out_ready  : output d can accept a flit
//   in_grant   : flit at input i transfers this cycle
//   out_valid  : output d carries a flit
//   out_sel    : crossbar select per output, out_sel[PW*d +: PW]
//   out_tail   : flit on output d is a tail
module wf_switch_allocator
    import noc_pkg::*;
#(
    parameter int unsigned NP = NP_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NP-1:0]    in_valid,
    input  logic [NP*NP-1:0] in_req,
    input  logic [NP-1:0]    in_tail,
    input  logic [NP-1:0]    out_ready,
    output logic [NP-1:0]    in_grant,
    output logic [NP-1:0]    out_valid,
    output logic [NP*PW-1:0] out_sel,
    output logic [NP-1:0]    out_tail
);

    out_state_e      state_q [NP];
    out_state_e      state_d [NP];
    logic [PW-1:0]   owner_q [NP];
    logic [PW-1:0]   owner_d [NP];
    logic [PW-1:0]   ptr_q   [NP];
    logic [PW-1:0]   ptr_d   [NP];

    logic [NP-1:0]   cand    [NP];  // cand[d][i]: input i qualified for output d
    logic [NP-1:0]   arb_gnt [NP];
    logic [PW-1:0]   arb_idx [NP];
    logic            arb_any [NP];

    logic [NP-1:0]   req_slice;
    logic [NP-1:0]   req_low;
    logic            xfer;
    logic [PW-1:0]   sel;

    // Qualification: only the lowest set request bit of a valid input counts.
    always_comb begin
        req_slice = '0;
        req_low   = '0;
        for (int unsigned d = 0; d < NP; d++) begin
            cand[d] = '0;
        end
        for (int unsigned i = 0; i < NP; i++) begin
            req_slice = in_req[NP*i +: NP];
            req_low   = req_slice & (~req_slice + NP'(1));
            for (int unsigned d = 0; d < NP; d++) begin
                cand[d][i] = in_valid[i] & req_low[d];
            end
        end
    end

    for (genvar d = 0; d < NP; d++) begin : g_out
        rr_arbiter #(
            .NP (NP),
            .PW (PW)
        ) u_arb (
            .req_i (cand[d]),
            .ptr_i (ptr_q[d]),
            .gnt_o (arb_gnt[d]),
            .idx_o (arb_idx[d]),
            .any_o (arb_any[d])
        );
    end

    always_comb begin
        in_grant  = '0;
        out_valid = '0;
        out_tail  = '0;
        out_sel   = '0;
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        xfer      = 1'b0;
        sel       = '0;
        for (int unsigned d = 0; d < NP; d++) begin
            if (state_q[d] == StIdle) begin
                xfer = arb_any[d] & out_ready[d];
                sel  = arb_idx[d];
                if (xfer) begin
                    in_grant   = in_grant | arb_gnt[d];
                    ptr_d[d]   = (arb_idx[d] == PW'(NP - 1)) ? '0 : arb_idx[d] + PW'(1);
                    owner_d[d] = arb_idx[d];
                    // Single-flit packets never take the lock.
                    state_d[d] = in_tail[arb_idx[d]] ? StIdle : StLocked;
                end
            end else begin
                xfer = cand[d][owner_q[d]] & out_ready[d];
                sel  = owner_q[d];
                if (xfer) begin
                    in_grant[owner_q[d]] = 1'b1;
                    if (in_tail[owner_q[d]]) begin
                        state_d[d] = StIdle;
                    end
                end
            end
            out_valid[d] = xfer;
            out_tail[d]  = xfer & in_tail[sel];
            if (xfer || state_q[d] == StLocked) begin
                out_sel[PW*d +: PW] = sel;
            end
        end
        // Outputs are forced quiet while reset is held, whatever the inputs do.
        if (reset) begin
            in_grant  = '0;
            out_valid = '0;
            out_tail  = '0;
            out_sel   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned d = 0; d < NP; d++) begin
                state_q[d] <= StIdle;
                owner_q[d] <= '0;
                ptr_q[d]   <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < NP; d++) begin
                state_q[d] <= state_d[d];
                owner_q[d] <= owner_d[d];
                ptr_q[d]   <= ptr_d[d];
            end
        end
    end

endmodule

// File: tb/tb_wf_switch_allocator.sv
module tb_wf_switch_allocator;

    localparam int NP = 5;
    localparam int PW = 3;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    in_valid;
    logic [NP*NP-1:0] in_req;
    logic [NP-1:0]    in_tail;
    logic [NP-1:0]    out_ready;
    logic [NP-1:0]    in_grant;
    logic [NP-1:0]    out_valid;
    logic [NP*PW-1:0] out_sel;
    logic [NP-1:0]    out_tail;

    int n_checks;
    int n_fail;

    wf_switch_allocator #(
        .NP (NP),
        .PW (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_req    (in_req),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .in_grant  (in_grant),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_tail  (out_tail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per output, owner index (-1 = free) and next-priority pointer.
    int m_own [NP];
    int m_ptr [NP];
    int m_win [NP];
    bit m_xfer[NP];
    logic [NP-1:0]    e_grant, e_valid, e_tail;
    logic [NP*PW-1:0] e_sel;
    logic [4*NP+NP*PW-1:0] e_vec, a_vec;

    function automatic int target(int i);
        if (!in_valid[i]) return -1;
        for (int b = 0; b < NP; b++) begin
            if (in_req[NP*i+b]) return b;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < NP; d++) begin
            m_own[d] = -1;
            m_ptr[d] = 0;
        end
    endfunction

    function automatic void model_comb();
        int c;
        e_grant = '0; e_valid = '0; e_tail = '0; e_sel = '0;
        for (int d = 0; d < NP; d++) begin
            m_xfer[d] = 0;
            m_win[d]  = m_own[d];
            if (reset) continue;
            if (m_own[d] < 0) begin
                for (int k = 0; k < NP; k++) begin
                    c = (m_ptr[d] + k) % NP;
                    if (target(c) == d) begin
                        m_win[d] = c;
                        break;
                    end
                end
                m_xfer[d] = (m_win[d] >= 0) && out_ready[d];
            end else begin
                m_xfer[d] = (target(m_own[d]) == d) && out_ready[d];
            end
            if (m_xfer[d]) begin
                e_grant[m_win[d]] = 1'b1;
                e_valid[d] = 1'b1;
                e_tail[d] = in_tail[m_win[d]];
                e_sel[PW*d +: PW] = 3'(m_win[d]);
            end else if (m_own[d] >= 0) begin
                e_sel[PW*d +: PW] = 3'(m_own[d]);
            end
        end
        e_vec = {e_grant, e_valid, e_sel, e_tail};
        a_vec = {in_grant, out_valid, out_sel, out_tail};
    endfunction

    function automatic void model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < NP; d++) begin
            if (!m_xfer[d]) continue;
            if (m_own[d] < 0) begin
                m_ptr[d] = (m_win[d] + 1) % NP;
                m_own[d] = in_tail[m_win[d]] ? -1 : m_win[d];
            end else if (in_tail[m_own[d]]) begin
                m_own[d] = -1;
            end
        end
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_req = '0; in_tail = '0; out_ready = '1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = '1; in_req = '1; in_tail = '1; out_ready = '1;
        #4;
        n_checks++;
        if ({in_grant, out_valid, out_sel, out_tail} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b valid=%b sel=%h tail=%b, want all zero",
                     in_grant, out_valid, out_sel, out_tail);
        end
        tick();
        model_reset();
        idle_inputs();
        reset = 1'b0;
        in_valid = 5'b00001; in_req[4:0] = 5'b00001; in_tail = 5'b00001;
        #4;
        model_comb();
        n_checks++;
        if (a_vec !== e_vec || in_grant !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h, want %h", a_vec, e_vec);
        end
        tick();
    endtask

    task automatic test_contention();
        int exp_seq[8] = '{1, 2, 3, 1, 2, 3, 4, 1};
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            in_valid[i] = 1'b1; in_tail[i] = 1'b1; in_req[NP*i +: NP] = 5'b00001;
        end
        for (int c = 0; c < 8; c++) begin
            if (c == 6) begin
                in_valid[4] = 1'b1; in_tail[4] = 1'b1; in_req[NP*4 +: NP] = 5'b00001;
            end
            #4;
            model_comb();
            n_checks++;
            if (a_vec !== e_vec || in_grant !== NP'(1 << exp_seq[c])) begin
                n_fail++;
                $display("FAIL contention cyc %0d: got grant=%b all=%h, want input %0d all=%h",
                         c, in_grant, a_vec, exp_seq[c], e_vec);
            end
            tick();
        end
    endtask

    task automatic test_wormhole();
        int sent2 = 0;
        bit done0 = 0;
        int tail_cyc = -1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            in_valid[2] = (sent2 < 4); in_tail[2] = (sent2 == 3); in_req[NP*2 +: NP] = 5'b01000;
            in_valid[0] = (c >= 1) && !done0; in_tail[0] = 1'b1; in_req[4:0] = 5'b01000;
            #4;
            model_comb();
            n_checks++;
            if (a_vec !== e_vec || (sent2 < 4 && c > 0 && out_sel[3*PW +: PW] !== 3'd2)) begin
                n_fail++;
                $display("FAIL wormhole cyc %0d: got %h sel3=%0d, want %h", c, a_vec,
                         out_sel[3*PW +: PW], e_vec);
            end
            if (e_grant[2] && in_tail[2]) tail_cyc = c;
            if (e_grant[0]) begin
                done0 = 1;
                n_checks++;
                if (tail_cyc < 0 || c != tail_cyc + 1) begin
                    n_fail++;
                    $display("FAIL wormhole_order: input 0 granted cyc %0d, want %0d", c,
                             tail_cyc + 1);
                end
            end
            if (e_grant[2]) sent2++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int sent = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            in_req[NP*4 +: NP] = 5'b00010;
            in_valid[4] = (sent < 5) && (c != 8) && (c != 9);
            in_tail[4] = (sent == 4);
            out_ready[1] = !(c >= 2 && c <= 4);
            #4;
            model_comb();
            n_checks++;
            if (a_vec !== e_vec) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d: got %h, want %h", c, a_vec, e_vec);
            end
            if (e_grant[4]) sent++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_parallel();
        do_reset();
        in_valid = 5'b01011; in_tail = 5'b01011;
        in_req[NP*0 +: NP] = 5'b10000;
        in_req[NP*1 +: NP] = 5'b00100;
        in_req[NP*3 +: NP] = 5'b00010;
        #4;
        model_comb();
        n_checks++;
        if (a_vec !== e_vec || in_grant !== 5'b01011 || out_valid !== 5'b10110 ||
            out_sel[4*PW +: PW] !== 3'd0 || out_sel[2*PW +: PW] !== 3'd1 ||
            out_sel[1*PW +: PW] !== 3'd3) begin
            n_fail++;
            $display("FAIL parallel: got grant=%b valid=%b sel=%h, want %h", in_grant,
                     out_valid, out_sel, e_vec);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid[1] = 1'b1; in_tail[1] = 1'b0; in_req[NP*1 +: NP] = 5'b00100;
        #4;
        model_comb();
        n_checks++;
        if (a_vec !== e_vec) begin
            n_fail++;
            $display("FAIL reset_mid_first: got %h, want %h", a_vec, e_vec);
        end
        tick();
        reset = 1'b1;
        #4;
        n_checks++;
        if ({in_grant, out_valid, out_sel, out_tail} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %h, want 0", {in_grant, out_valid, out_sel,
                     out_tail});
        end
        tick();
        reset = 1'b0;
        in_valid = 5'b01000; in_tail = 5'b01000; in_req = '0;
        in_req[NP*3 +: NP] = 5'b01100;
        #4;
        model_comb();
        n_checks++;
        if (a_vec !== e_vec || in_grant !== 5'b01000 || out_valid !== 5'b00100 ||
            out_sel[2*PW +: PW] !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_mid_new_owner: got %h, want %h", a_vec, e_vec);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                in_req[NP*i +: NP] = ($urandom_range(0, 3) == 0) ? NP'($urandom) :
                                     NP'(1 << $urandom_range(0, NP-1));
            end
            in_valid  = NP'($urandom);
            in_tail   = NP'($urandom);
            out_ready = NP'($urandom) | NP'($urandom);
            #4;
            model_comb();
            n_checks++;
            if (a_vec !== e_vec) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h, want %h", c, a_vec, e_vec);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        model_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_contention();
        test_wormhole();
        test_backpressure();
        test_parallel();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
